// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - execute-stage <-> divider handshake bundle
// Optional DIV_ZERO_FLAG_EN adds the div_by_zero_o flag.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic                  div_by_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_by_zero_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_by_zero_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
`endif
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring DIV/DIVU unit, one quotient bit per cycle
// Optional DIV_ZERO_FLAG_EN drives div_by_zero_o alongside a zero-divisor result.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W-1:0]   work_q;
  logic [DATA_W-1:0]     divisor_q;
  logic                  signed_q;
  logic                  neg1_q;
  logic                  neg2_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;
`ifdef DIV_ZERO_FLAG_EN
  logic                  dbz_q;
`endif

  logic [DATA_W:0]       diff_d;
  logic [DATA_W-1:0]     quot_d;
  logic [DATA_W-1:0]     rem_d;
  logic [DATA_W-1:0]     abs1_d;
  logic [DATA_W-1:0]     abs2_d;
  logic                  neg1_d;
  logic                  neg2_d;

  // Trial subtraction on the partial remainder as it will look after the shift.
  assign diff_d = work_q[2*DATA_W-1:DATA_W-1] - {1'b0, divisor_q};

  assign quot_d = (signed_q && (neg1_q ^ neg2_q)) ? -work_q[DATA_W-1:0]
                                                 :  work_q[DATA_W-1:0];
  assign rem_d  = (signed_q && neg1_q) ? -work_q[2*DATA_W-1:DATA_W]
                                       :  work_q[2*DATA_W-1:DATA_W];

  assign neg1_d = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign neg2_d = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign abs1_d = neg1_d ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2_d = neg2_d ? -bus.opdata2_i : bus.opdata2_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
          dbz_q    <= 1'b0;
`endif
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q   <= S_ON;
              signed_q  <= bus.signed_div_i;
              neg1_q    <= neg1_d;
              neg2_q    <= neg2_d;
              work_q    <= {{DATA_W{1'b0}}, abs1_d};
              divisor_q <= abs2_d;
              cnt_q     <= '0;
            end
          end
        end
        S_BYZERO: begin
          state_q  <= S_END;
          result_q <= '0;
          ready_q  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          dbz_q    <= 1'b1;
`endif
        end
        S_ON: begin
          if (bus.annul_i) begin
            state_q <= S_FREE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(DATA_W)) begin
            state_q  <= S_END;
            result_q <= {rem_d, quot_d};
            ready_q  <= 1'b1;
          end else begin
            if (diff_d[DATA_W]) begin
              work_q <= {work_q[2*DATA_W-2:0], 1'b0};
            end else begin
              work_q <= {diff_d[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_END: begin
          // Result is held for the initiator until it drops start_i; annul is ignored here.
          if (!bus.start_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dbz_q    <= 1'b0;
`endif
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_by_zero_o = dbz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    logic [31:0] ql, rl;
    if (b == 0) return 64'd0;
    if (!sg) begin
      ql = a / b;
      rl = a % b;
      return {rl, ql};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = ma / mb;
    r  = ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    ql = q[31:0];
    rl = r[31:0];
    return {rl, ql};
  endfunction

  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble);
    logic [63:0] exp;
    int lat;
    int exp_lat;
    exp     = model(sg, a, b);
    exp_lat = (b == 0) ? 2 : 34;
    @(negedge clk);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    if (scramble) begin
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
    end
    while (!bus.ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", bus.result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
    check("dbz_flag", 64'(bus.div_by_zero_o), 64'(b == 0));
`endif
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("ready_clear", 64'(bus.ready_o), 64'd0);
    check("result_clear", bus.result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    int          seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the plan.
    run_op(1'b0, 32'd100, 32'd7, 1'b1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);

    // Flush at iteration 10: nothing must come back.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0);

    // annul held in FREE blocks acceptance.
    @(negedge clk);
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    check("annul_free_block", 64'(seen), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // annul in END leaves the result held.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd6;
    bus.start_i      = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check("end_ready", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("end_annul_ready", 64'(bus.ready_o), 64'd1);
    check("end_annul_result", bus.result_o, model(1'b0, 32'd50, 32'd6));

    // Asynchronous reset while the result is held: clears without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(bus.ready_o), 64'd0);
    check("async_rst_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    rst = 1'b0;

    // Reset mid-iteration aborts the operation.
    @(negedge clk);
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    check("rst_abort_no_ready", 64'(seen), 64'd0);

    // Randomized operations, with divisor sizes spread out and occasional zero.
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = $urandom >> $urandom_range(0, 31);
        2:       rb = -32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op(rs, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
